if_prefetch: RTL and testbench
==============================

# if_prefetch

Parametrised instruction-fetch stage with a prefetch queue: a successor to the single-register fetch stage. It issues sequential fetches to instruction memory over a req/ack handshake that tolerates wait states, buffers up to DEPTH returned instructions, and presents them to decode in order. A taken branch or jump (`if_pc_jump`) flushes the queue and restarts fetch at `jpc`. `if_bubble` stalls consumption without stalling prefetch.

## Interface
- RESET_PC, 32'h80000000, first fetch address after reset
- DEPTH, 4, queue entries; power of two, minimum 2
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active-high
- jpc  in  32  redirect target; sampled only when `if_pc_jump`=1
- if_pc_jump  in  1  redirect request: flush the queue and refetch from `jpc`
- if_bubble  in  1  decode stall: the head entry is not consumed this cycle
- im_req  out  1  fetch request, registered
- im_addr  out  32  fetch address, registered; stable while `im_req`=1 and `im_ack`=0
- im_ack  in  1  memory accepts the request; `im_data` is valid in the same cycle
- im_data  in  32  fetched word
- ins_valid  out  1  queue head holds a valid instruction
- ins  out  32  head instruction; 32'h0 when `ins_valid`=0
- ins_pc  out  32  address of the head instruction
- npc  out  32  `ins_pc` + 4, modulo 2^32
- count  out  $clog2(DEPTH+1)  current queue occupancy

## Operation
- Queue: circular buffer of {pc, instr}, indexed by rd_ptr and wr_ptr of $clog2(DEPTH) bits each. Pointers wrap naturally. `count` ranges from 0 to DEPTH.
- Push: on a cycle with `im_req`&`im_ack`, the pair {im_addr, im_data} is written at wr_ptr, unless the drop flag is set or `if_pc_jump`=1.
- Pop: on a cycle with `ins_valid`&!`if_bubble`&!`if_pc_jump`, rd_ptr advances.
- A push and a pop in the same cycle leave `count` unchanged. A push while full cannot occur, because of the issue rule.
- Issue rule, evaluated at each edge when no transaction is pending or when one completes:
  - next `im_req` = (count_next < DEPTH) and no drop-only transaction is outstanding.
  - Each ack advances `im_addr` by 4.
  - While `im_req`=1 and `im_ack`=0, `im_req` and `im_addr` are held.
- Redirect, when `if_pc_jump`=1 at an edge:
  - The redirect has priority over push, pop and `if_bubble`.
  - The queue is cleared: rd_ptr = wr_ptr = 0, count = 0.
  - Case A, no transaction waiting, or `im_ack`=1 this cycle: next `im_addr` = `jpc` and `im_req` = 1. Any data acked in this cycle is discarded.
  - Case B, transaction waiting (`im_req`=1, `im_ack`=0): `jpc` is latched into target_pc and the drop flag is set. The waiting request stays on the bus unchanged. On its ack the data is discarded and the drop flag clears; the next `im_addr` = target_pc.
  - A second redirect while the drop flag is set overwrites target_pc. The last redirect wins.
- State machine:
  - IDLE (`im_req`=0) goes to REQ when count_next < DEPTH.
  - REQ goes to REQ on an ack when space remains, or to IDLE on an ack when the queue will be full.
  - REQ goes to DROP on a redirect without an ack.
  - DROP goes to REQ on an ack, with `im_addr` = target_pc.
- Arithmetic: all PC arithmetic is 32-bit and wraps modulo 2^32. `jpc` is used unmodified; alignment is not checked here.

## Timing
- Reset values: `im_req`=0, `im_addr`=RESET_PC, queue empty, `count`=0, `ins_valid`=0, `ins`=0, `ins_pc`=RESET_PC, `npc`=RESET_PC+4, drop flag 0, target_pc=RESET_PC.
- When empty, `ins_pc` and `npc` hold the last popped or redirect value; only `ins_valid` qualifies them.
- Reset mid-transaction abandons it. The memory must tolerate `im_req` dropping without an ack.
- Startup: the first edge with `rst`=0 sets `im_req`=1 and `im_addr`=RESET_PC.
- Zero-wait-state memory (`im_ack` tied to 1):
  - Fetch-to-`ins_valid` latency is 1 cycle.
  - Sustained throughput is 1 instruction per cycle.
  - Redirect penalty: `jpc` appears on `im_addr` 1 cycle after the redirect edge, and its instruction is valid at decode 2 cycles after it.
- `ins`, `ins_pc`, `npc` and `ins_valid` are combinational from the queue head. There is no bypass from `im_data` to `ins`.

## Test plan
- Reset release with `im_ack` tied to 1 and `if_bubble`=0:
  - `im_addr` = 80000000, 80000004, ... on consecutive cycles.
  - `ins_valid` rises one cycle later.
  - `ins_pc` / `npc` = 80000000 / 80000004, with `ins` matching memory.
- Hold `if_bubble`=1 for 10 cycles (DEPTH=4):
  - `count` saturates at 4 and `im_req` drops.
  - Releasing `if_bubble` drains the queue in order with no instruction lost or duplicated.
- `im_ack` delayed 3 cycles per request:
  - `im_addr` is stable during each wait.
  - `ins_valid` pattern is 1 instruction every 4 cycles.
- Redirect to `jpc`=80001000 while the queue holds 3 entries and no request is waiting:
  - Next cycle `count`=0 and `im_addr`=80001000.
  - `ins_pc`=80001000 two cycles after the redirect.
- Redirect to 80002000 while a request is waiting, then a second redirect to 80003000 before the ack:
  - The old request is held until its ack.
  - Its data is never pushed.
  - The next `im_addr` is 80003000.
- Redirect with `jpc`=FFFFFFFC: fetches FFFFFFFC, then 00000000. `npc` wraps to 00000000.

Source files
------------

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue.
// Sequential fetch over req/ack with wait states; redirects flush the queue and restart at jpc.
module if_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                jpc,
    input  logic                       if_pc_jump,
    input  logic                       if_bubble,
    output logic                       im_req,
    output logic [31:0]                im_addr,
    input  logic                       im_ack,
    input  logic [31:0]                im_data,
    output logic                       ins_valid,
    output logic [31:0]                ins,
    output logic [31:0]                ins_pc,
    output logic [31:0]                npc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP
    } state_t;

    state_t          state, state_nx;
    logic [31:0]     addr_nx;
    logic [31:0]     target_pc, target_nx;
    logic [31:0]     hold_pc;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   cnt_nx;
    logic [31:0]     pc_q  [DEPTH];
    logic [31:0]     ins_q [DEPTH];
    logic            hs, waiting, push, pop, space;

    assign hs      = im_req & im_ack;
    assign waiting = im_req & ~im_ack;
    assign push    = hs & (state != S_DROP) & ~if_pc_jump;
    assign pop     = ins_valid & ~if_bubble & ~if_pc_jump;

    always_comb begin
        cnt_nx = count;
        if (if_pc_jump) begin
            cnt_nx = '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt_nx = count + CW'(1);
                2'b01:   cnt_nx = count - CW'(1);
                default: cnt_nx = count;
            endcase
        end
    end

    assign space = (cnt_nx < CW'(DEPTH));

    always_comb begin
        state_nx  = state;
        addr_nx   = im_addr;
        target_nx = target_pc;
        if (if_pc_jump) begin
            // A waiting request cannot be withdrawn: let it finish and discard its data.
            if (waiting) begin
                state_nx  = S_DROP;
                target_nx = jpc;
            end else begin
                state_nx = S_REQ;
                addr_nx  = jpc;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (space) state_nx = S_REQ;
                end
                S_REQ: begin
                    if (im_ack) begin
                        addr_nx  = im_addr + 32'd4;
                        state_nx = space ? S_REQ : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (im_ack) begin
                        addr_nx  = target_pc;
                        state_nx = S_REQ;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            im_req    <= 1'b0;
            im_addr   <= RESET_PC;
            target_pc <= RESET_PC;
        end else begin
            state     <= state_nx;
            im_req    <= (state_nx != S_IDLE);
            im_addr   <= addr_nx;
            target_pc <= target_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || if_pc_jump) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= cnt_nx;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]  <= im_addr;
            ins_q[wr_ptr] <= im_data;
        end
    end

    // Keeps ins_pc/npc meaningful while the queue is empty.
    always_ff @(posedge clk) begin
        if (rst)             hold_pc <= RESET_PC;
        else if (if_pc_jump) hold_pc <= jpc;
        else if (pop)        hold_pc <= pc_q[rd_ptr];
    end

    assign ins_valid = (count != '0);
    assign ins       = ins_valid ? ins_q[rd_ptr] : '0;
    assign ins_pc    = ins_valid ? pc_q[rd_ptr] : hold_pc;
    assign npc       = ins_pc + 32'd4;

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: queue-based transaction model plus directed scenarios.
module tb_if_prefetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          DEPTH  = 4;
    localparam int          CW     = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   jpc;
    logic          if_pc_jump, if_bubble;
    logic          im_req;
    logic [31:0]   im_addr;
    logic          im_ack;
    logic [31:0]   im_data;
    logic          ins_valid;
    logic [31:0]   ins, ins_pc, npc;
    logic [CW-1:0] count;

    if_prefetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .jpc(jpc), .if_pc_jump(if_pc_jump), .if_bubble(if_bubble),
        .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_data(im_data),
        .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc), .npc(npc), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // memory and model state
    int          wcnt = 0;
    int          ack_delay = 0;
    bit          ack_rand = 0;
    bit          last_hs = 0;
    int          pops = 0;
    logic [31:0] mq[$];
    bit          m_req = 0, m_drop = 0;
    logic [31:0] m_addr = RST_PC, m_target = RST_PC;
    bit          e_valid;
    logic [CW-1:0] e_cnt;
    logic [31:0] e_pc, e_ins;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Drive one cycle at negedge, advance the model across the rising edge, return at next negedge.
    task automatic step(input bit b, input bit j, input logic [31:0] t);
        bit hs, wt, pp;
        if_bubble  = b;
        if_pc_jump = j;
        jpc        = t;
        if (ack_rand) im_ack = im_req && ($urandom_range(0, 2) == 0);
        else          im_ack = im_req && (wcnt >= ack_delay);
        im_data = mem(im_addr);
        hs = m_req && im_ack;
        wt = m_req && !im_ack;
        pp = (mq.size() != 0) && !b && !j;
        last_hs = (im_req === 1'b1) && (im_ack === 1'b1);
        if (rst) begin
            mq.delete();
            m_req = 0; m_drop = 0; m_addr = RST_PC; m_target = RST_PC;
        end else if (j) begin
            mq.delete();
            if (wt) begin
                m_drop = 1; m_target = t;
            end else begin
                m_drop = 0; m_addr = t; m_req = 1;
            end
        end else begin
            if (pp) begin
                void'(mq.pop_front());
                pops++;
            end
            if (hs) begin
                if (!m_drop) mq.push_back(m_addr);
                m_addr = m_drop ? m_target : m_addr + 32'd4;
                m_drop = 0;
                m_req  = (mq.size() < DEPTH);
            end else if (!m_req) begin
                m_req = (mq.size() < DEPTH);
            end
        end
        wcnt = (!rst && im_req === 1'b1 && im_ack === 1'b0) ? wcnt + 1 : 0;
        @(posedge clk);
        @(negedge clk);
        e_valid = (mq.size() != 0);
        e_cnt   = CW'(mq.size());
        e_pc    = e_valid ? mq[0] : 32'h0;
        e_ins   = e_valid ? mem(mq[0]) : 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ack_delay = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0);
        total++;
        if (im_req !== 1'b0 || im_addr !== RST_PC || count !== '0) begin
            bad++;
            $display("FAIL reset_bus req=%b addr=%h cnt=%0d want 0 %h 0", im_req, im_addr, count, RST_PC);
        end
        total++;
        if (ins_valid !== 1'b0 || ins !== 32'h0 || ins_pc !== RST_PC || npc !== RST_PC + 32'd4) begin
            bad++;
            $display("FAIL reset_head v=%b ins=%h pc=%h npc=%h want 0 0 %h %h", ins_valid, ins, ins_pc, npc,
                     RST_PC, RST_PC + 32'd4);
        end
    endtask

    task automatic test_stream();
        rst = 1'b0;
        step(0, 0, 32'h0);
        total++;
        if (im_req !== 1'b1 || im_addr !== RST_PC || ins_valid !== 1'b0) begin
            bad++;
            $display("FAIL start_first req=%b addr=%h v=%b want 1 %h 0", im_req, im_addr, ins_valid, RST_PC);
        end
        step(0, 0, 32'h0);
        total++;
        if (ins_valid !== 1'b1 || ins_pc !== RST_PC || npc !== RST_PC + 32'd4 || ins !== mem(RST_PC) ||
            im_addr !== RST_PC + 32'd4) begin
            bad++;
            $display("FAIL start_valid v=%b pc=%h npc=%h ins=%h addr=%h want 1 %h %h %h %h", ins_valid, ins_pc,
                     npc, ins, im_addr, RST_PC, RST_PC + 32'd4, mem(RST_PC), RST_PC + 32'd4);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 32'h0);
            total++;
            if (im_req !== m_req || im_addr !== m_addr) begin
                bad++;
                $display("FAIL stream_bus t=%0t req=%b addr=%h want %b %h", $time, im_req, im_addr, m_req, m_addr);
            end
            total++;
            if (ins_valid !== e_valid || count !== e_cnt || ins !== e_ins ||
                (e_valid && (ins_pc !== e_pc || npc !== e_pc + 32'd4))) begin
                bad++;
                $display("FAIL stream_head t=%0t v=%b cnt=%0d ins=%h pc=%h want %b %0d %h %h", $time, ins_valid,
                         count, ins, ins_pc, e_valid, e_cnt, e_ins, e_pc);
            end
        end
    endtask

    task automatic test_bubble();
        for (int i = 0; i < 22; i++) begin
            step(i < 10, 0, 32'h0);
            if (i == 9) begin
                total++;
                if (count !== CW'(DEPTH) || im_req !== 1'b0) begin
                    bad++;
                    $display("FAIL bubble_full cnt=%0d req=%b want %0d 0", count, im_req, DEPTH);
                end
            end
            total++;
            if (im_req !== m_req || im_addr !== m_addr) begin
                bad++;
                $display("FAIL bubble_bus t=%0t req=%b addr=%h want %b %h", $time, im_req, im_addr, m_req, m_addr);
            end
            total++;
            if (ins_valid !== e_valid || count !== e_cnt || ins !== e_ins ||
                (e_valid && (ins_pc !== e_pc || npc !== e_pc + 32'd4))) begin
                bad++;
                $display("FAIL bubble_head t=%0t v=%b cnt=%0d ins=%h pc=%h want %b %0d %h %h", $time, ins_valid,
                         count, ins, ins_pc, e_valid, e_cnt, e_ins, e_pc);
            end
        end
    endtask

    task automatic test_wait();
        ack_delay = 3;
        for (int i = 0; i < 24; i++) begin
            if (i == 8) pops = 0;
            step(0, 0, 32'h0);
            total++;
            if (im_req !== m_req || im_addr !== m_addr) begin
                bad++;
                $display("FAIL wait_bus t=%0t req=%b addr=%h want %b %h", $time, im_req, im_addr, m_req, m_addr);
            end
            total++;
            if (ins_valid !== e_valid || count !== e_cnt || ins !== e_ins ||
                (e_valid && (ins_pc !== e_pc || npc !== e_pc + 32'd4))) begin
                bad++;
                $display("FAIL wait_head t=%0t v=%b cnt=%0d ins=%h pc=%h want %b %0d %h %h", $time, ins_valid,
                         count, ins, ins_pc, e_valid, e_cnt, e_ins, e_pc);
            end
        end
        total++;
        if (pops != 4) begin
            bad++;
            $display("FAIL wait_rate consumed=%0d in 16 cycles want 4", pops);
        end
    endtask

    task automatic test_redirect_idle();
        ack_delay = 0;
        step(1, 1, 32'h8000_0800);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0);
        total++;
        if (count !== CW'(3)) begin
            bad++;
            $display("FAIL redir_fill cnt=%0d want 3", count);
        end
        step(1, 1, 32'h8000_1000);
        total++;
        if (count !== '0 || im_addr !== 32'h8000_1000 || im_req !== 1'b1) begin
            bad++;
            $display("FAIL redir_flush cnt=%0d addr=%h req=%b want 0 80001000 1", count, im_addr, im_req);
        end
        step(0, 0, 32'h0);
        total++;
        if (ins_valid !== 1'b1 || ins_pc !== 32'h8000_1000 || ins !== mem(32'h8000_1000)) begin
            bad++;
            $display("FAIL redir_target v=%b pc=%h ins=%h want 1 80001000 %h", ins_valid, ins_pc, ins,
                     mem(32'h8000_1000));
        end
    endtask

    task automatic test_drop();
        logic [31:0] old;
        bit          found;
        ack_delay = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0, 32'h0);
            found = last_hs && (im_req === 1'b1);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL drop_setup no handshake seen within 20 cycles");
        end
        old = im_addr;
        step(0, 1, 32'h8000_2000);
        step(0, 1, 32'h8000_3000);
        total++;
        if (im_req !== 1'b1 || im_addr !== old || count !== '0) begin
            bad++;
            $display("FAIL drop_hold req=%b addr=%h cnt=%0d want 1 %h 0", im_req, im_addr, count, old);
        end
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(0, 0, 32'h0);
            found = last_hs;
            total++;
            if (!found && (im_addr !== old || count !== '0)) begin
                bad++;
                $display("FAIL drop_wait addr=%h cnt=%0d want %h 0", im_addr, count, old);
            end
        end
        total++;
        if (!found || im_addr !== 32'h8000_3000 || count !== '0 || ins_valid !== 1'b0) begin
            bad++;
            $display("FAIL drop_retarget acked=%b addr=%h cnt=%0d v=%b want 1 80003000 0 0", found, im_addr, count,
                     ins_valid);
        end
    endtask

    task automatic test_wrap();
        ack_delay = 0;
        step(0, 1, 32'hFFFF_FFFC);
        total++;
        if (im_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_issue addr=%h want fffffffc", im_addr);
        end
        step(0, 0, 32'h0);
        total++;
        if (im_addr !== 32'h0 || ins_valid !== 1'b1 || ins_pc !== 32'hFFFF_FFFC || npc !== 32'h0) begin
            bad++;
            $display("FAIL wrap_npc addr=%h v=%b pc=%h npc=%h want 0 1 fffffffc 0", im_addr, ins_valid, ins_pc, npc);
        end
        step(0, 0, 32'h0);
        total++;
        if (ins_pc !== 32'h0 || ins !== mem(32'h0)) begin
            bad++;
            $display("FAIL wrap_next pc=%h ins=%h want 0 %h", ins_pc, ins, mem(32'h0));
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        ack_rand = 1;
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            t = {$urandom(), 2'b00} >> 0;
            t = {t[31:2], 2'b00};
            if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF8;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, t);
            total++;
            if (im_req !== m_req || im_addr !== m_addr) begin
                bad++;
                $display("FAIL rand_bus t=%0t req=%b addr=%h want %b %h", $time, im_req, im_addr, m_req, m_addr);
            end
            total++;
            if (ins_valid !== e_valid || count !== e_cnt || ins !== e_ins ||
                (e_valid && (ins_pc !== e_pc || npc !== e_pc + 32'd4))) begin
                bad++;
                $display("FAIL rand_head t=%0t v=%b cnt=%0d ins=%h pc=%h want %b %0d %h %h", $time, ins_valid,
                         count, ins, ins_pc, e_valid, e_cnt, e_ins, e_pc);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; jpc = '0; if_pc_jump = 1'b0; if_bubble = 1'b0; im_ack = 1'b0; im_data = '0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_bubble();
        test_wait();
        test_redirect_idle();
        test_drop();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
